// File: rtl/adc_spi_capture_if.sv
// rtl/adc_spi_capture_if.sv - SPI pin bundle between the capture front end and the serial ADC
interface adc_spi_capture_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_sdata;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        input  adc_sdata
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        output adc_sdata
    );
endinterface

// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - turns each sample_trigger rising edge into one SPI frame on a serial ADC
module adc_spi_capture #(
    parameter int SCLK_HALF    = 4,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int QUIET_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_trigger,
    adc_spi_capture_if.master    spi,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [7:0]           overrun_count
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [HW-1:0] HALF_LAST  = HW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    state_t                 state;
    logic                   trig_d;
    logic                   trig_edge;
    logic                   cs_n_q;
    logic                   sclk_q;
    logic [HW-1:0]          half_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [QW-1:0]          quiet_cnt;
    // Only the low DATA_BITS are kept; older frame bits fall off the top.
    logic [DATA_BITS-1:0]   shift_q;

    assign trig_edge     = sample_trigger & ~trig_d;
    assign spi.adc_cs_n  = cs_n_q;
    assign spi.adc_sclk  = sclk_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            quiet_cnt    <= '0;
            shift_q      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state    <= SETUP;
                        cs_n_q   <= 1'b0;
                        half_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (half_cnt == HALF_LAST) begin
                        state    <= SHIFT;
                        sclk_q   <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (!sclk_q) begin
                            // Capture on the same edge that raises SCLK.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[DATA_BITS-2:0], spi.adc_sdata};
                        end else if (bit_cnt == BIT_LAST) begin
                            state        <= QUIET;
                            cs_n_q       <= 1'b1;
                            sample       <= shift_q;
                            sample_valid <= 1'b1;
                            quiet_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            sclk_q  <= 1'b0;
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                QUIET: begin
                    if (quiet_cnt == QUIET_LAST) begin
                        state <= IDLE;
                    end else begin
                        quiet_cnt <= quiet_cnt + QW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // trig_d resets high so a trigger already asserted at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d        <= 1'b1;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            trig_d  <= sample_trigger;
            overrun <= 1'b0;
            if (trig_edge && (state != IDLE)) begin
                overrun <= 1'b1;
                if (overrun_count != 8'hFF) begin
                    overrun_count <= overrun_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb/tb_adc_spi_capture.sv - directed bench for adc_spi_capture with a behavioural serial ADC
module tb_adc_spi_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_trigger = 1'b1;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic [7:0]  overrun_count;

    adc_spi_capture_if spi_bus ();

    adc_spi_capture dut (
        .clk           (clk),
        .rst           (rst),
        .sample_trigger(sample_trigger),
        .spi           (spi_bus),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    // ADC model: frame loads on CS fall, MSB out first, advances after each SCLK rise.
    logic [15:0] adc_frame = 16'h0000;
    logic [15:0] adc_sr    = 16'h0000;
    int          sclk_rises = 0;

    assign spi_bus.adc_sdata = adc_sr[15];

    always @(negedge spi_bus.adc_cs_n) adc_sr = adc_frame;

    always @(posedge spi_bus.adc_sclk) begin
        if (spi_bus.adc_cs_n === 1'b0) begin
            #1;
            adc_sr = adc_sr << 1;
            sclk_rises++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          w_first_cs, w_last_fall, w_falls, w_valids, w_first_valid, w_ovr, w_first_sclk_low, w_cs_low;
    logic        w_busy137, w_busy138;
    logic [11:0] w_valid_sample;
    logic [31:0] w_rst_cs, w_rst_sclk, w_rst_busy, w_rst_sample, w_rst_cnt;

    // Relative cycle 0 is the edge-detect cycle E; outputs are sampled before inputs are driven.
    task automatic run_window(input logic [15:0] frame, input int len, input int rise2, input int rst_at);
        logic prev_cs;
        adc_frame        = frame;
        sclk_rises       = 0;
        w_first_cs       = -1;
        w_last_fall      = -1;
        w_falls          = 0;
        w_valids         = 0;
        w_first_valid    = -1;
        w_ovr            = 0;
        w_first_sclk_low = -1;
        w_valid_sample   = '0;
        w_busy137        = 1'b0;
        w_busy138        = 1'b1;
        prev_cs          = 1'b1;
        for (int rel = 0; rel < len; rel++) begin
            @(negedge clk);
            if (spi_bus.adc_cs_n === 1'b0 && prev_cs === 1'b1) begin
                w_falls++;
                w_last_fall = rel;
                if (w_first_cs < 0) w_first_cs = rel;
            end
            prev_cs = spi_bus.adc_cs_n;
            if (spi_bus.adc_sclk === 1'b0 && w_first_sclk_low < 0) w_first_sclk_low = rel;
            if (sample_valid) begin
                w_valids++;
                if (w_first_valid < 0) begin
                    w_first_valid  = rel;
                    w_valid_sample = sample;
                end
            end
            if (overrun) w_ovr++;
            if (rel == 137) w_busy137 = busy;
            if (rel == 138) w_busy138 = busy;
            if (rst_at >= 0 && rel == rst_at + 1) begin
                w_rst_cs     = 32'(spi_bus.adc_cs_n);
                w_rst_sclk   = 32'(spi_bus.adc_sclk);
                w_rst_busy   = 32'(busy);
                w_rst_sample = 32'(sample);
                w_rst_cnt    = 32'(overrun_count);
                rst          = 1'b0;
            end
            if (rel == 0 || rel == rise2) sample_trigger = 1'b1;
            if (rel == 2 || (rise2 >= 0 && rel == rise2 + 2)) sample_trigger = 1'b0;
            if (rel == rst_at) rst = 1'b1;
        end
    endtask

    task automatic idle_watch(input int n);
        w_valids = 0;
        w_cs_low = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sample_valid) w_valids++;
            if (spi_bus.adc_cs_n !== 1'b1) w_cs_low++;
        end
    endtask

    initial begin
        int pulses;
        int div_valids;
        int last_valid;
        int first_valid;

        // Reset with the trigger already high.
        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", 32'(spi_bus.adc_cs_n), 32'd1);
        check_eq("rst_sclk", 32'(spi_bus.adc_sclk), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sample", 32'(sample), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_ovr_count", 32'(overrun_count), 32'd0);
        rst = 1'b0;
        idle_watch(30);
        check_eq("held_trig_no_cs", 32'(w_cs_low), 32'd0);
        check_eq("held_trig_not_busy", 32'(busy), 32'd0);
        sample_trigger = 1'b0;
        idle_watch(3);

        // Frame 0x0ABC: full timing.
        run_window(16'h0ABC, 160, -1, -1);
        check_eq("abc_cs_low_at", 32'(w_first_cs), 32'd1);
        check_eq("abc_sclk_fall_at", 32'(w_first_sclk_low), 32'd5);
        check_eq("abc_sclk_rises", 32'(sclk_rises), 32'd16);
        check_eq("abc_valid_at", 32'(w_first_valid), 32'd133);
        check_eq("abc_valid_count", 32'(w_valids), 32'd1);
        check_eq("abc_sample", 32'(w_valid_sample), 32'h0ABC);
        check_eq("abc_cs_falls", 32'(w_falls), 32'd1);
        check_eq("abc_busy_137", 32'(w_busy137), 32'd1);
        check_eq("abc_busy_138", 32'(w_busy138), 32'd0);
        check_eq("abc_no_overrun", 32'(w_ovr), 32'd0);

        // Upper frame bits are discarded; sample holds between frames.
        run_window(16'hF5A5, 160, -1, -1);
        check_eq("f5a5_sample", 32'(w_valid_sample), 32'h05A5);
        idle_watch(100);
        check_eq("hold_no_valid", 32'(w_valids), 32'd0);
        check_eq("hold_sample", 32'(sample), 32'h05A5);

        run_window(16'h0000, 160, -1, -1);
        check_eq("zero_valid_count", 32'(w_valids), 32'd1);
        check_eq("zero_sample", 32'(w_valid_sample), 32'h0000);

        // Edge in the first IDLE cycle after QUIET is accepted.
        run_window(16'h0123, 290, 138, -1);
        check_eq("b2b_cs_falls", 32'(w_falls), 32'd2);
        check_eq("b2b_second_cs_at", 32'(w_last_fall), 32'd139);
        check_eq("b2b_no_overrun", 32'(w_ovr), 32'd0);
        check_eq("b2b_valids", 32'(w_valids), 32'd2);
        check_eq("b2b_sample", 32'(sample), 32'h0123);

        // Edge at E+50 is dropped.
        run_window(16'h0456, 160, 50, -1);
        check_eq("ovr_pulses", 32'(w_ovr), 32'd1);
        check_eq("ovr_count", 32'(overrun_count), 32'd1);
        check_eq("ovr_cs_falls", 32'(w_falls), 32'd1);
        check_eq("ovr_sample", 32'(w_valid_sample), 32'h0456);

        // Reset at E+60 aborts the frame.
        run_window(16'h0789, 200, -1, 60);
        check_eq("midrst_cs_n", w_rst_cs, 32'd1);
        check_eq("midrst_sclk", w_rst_sclk, 32'd1);
        check_eq("midrst_busy", w_rst_busy, 32'd0);
        check_eq("midrst_sample", w_rst_sample, 32'd0);
        check_eq("midrst_ovr_count", w_rst_cnt, 32'd0);
        check_eq("midrst_no_valid", 32'(w_valids), 32'd0);
        check_eq("midrst_sample_after", 32'(sample), 32'd0);

        // Flood of trigger edges saturates the overrun counter.
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (overrun) pulses++;
            sample_trigger = (i % 2 == 0);
        end
        sample_trigger = 1'b0;
        idle_watch(2);
        check_eq("sat_count", 32'(overrun_count), 32'd255);
        check_eq("sat_enough_pulses", 32'(pulses >= 255), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_eq("sat_cleared", 32'(overrun_count), 32'd0);
        idle_watch(5);

        // Divider-rate trigger: 3000-cycle period, 50% duty.
        div_valids  = 0;
        last_valid  = -1;
        first_valid = -1;
        for (int i = 0; i < 30200; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                div_valids++;
                if (last_valid < 0) first_valid = i;
                else check_eq("div_spacing", 32'(i - last_valid), 32'd3000);
                last_valid = i;
            end
            sample_trigger = (i < 30000) && ((i % 3000) < 1500);
        end
        check_eq("div_first_valid", 32'(first_valid), 32'd133);
        check_eq("div_valid_count", 32'(div_valids), 32'd10);
        check_eq("div_no_overrun", 32'(overrun_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
